slt_operand_stage: RTL
======================

Name: slt_operand_stage

Overview:
- Execute-side issue stage directly upstream of the 32-bit set-less-than comparator; owns the operand registers that drive the comparator's I_OP_A/I_OP_B.
- Accepts decoded SLT/SLTU/SLTI/SLTIU micro-ops over a valid/ready handshake and selects rs2 or the sign-extended immediate.
- For unsigned ops, inverts bit 31 of both operands so the comparator's signed compare yields the unsigned result.
- Registers the prepared operands plus the destination register tag behind a 2-entry skid buffer, so upstream ready is driven from a flop.

Parameters:
- DATA_W, 32, operand width; comparator is fixed at 32, so only 32 is supported.
- IMM_W, 12, immediate width; sign-extended to DATA_W.
- RD_W, 5, destination register tag width.

Ports:
- I_CLK  input  1  clock, rising edge.
- I_RST_N  input  1  asynchronous reset, active-low.
- I_FLUSH  input  1  synchronous pipeline flush.
- I_VALID  input  1  upstream micro-op valid.
- O_READY  output  1  stage can accept a micro-op this cycle.
- I_RS1_DATA  input  DATA_W  rs1 value.
- I_RS2_DATA  input  DATA_W  rs2 value.
- I_RS1_ADDR  input  RD_W  rs1 index; used only with SLT_FWD_EN.
- I_RS2_ADDR  input  RD_W  rs2 index; used only with SLT_FWD_EN.
- I_IMM  input  IMM_W  raw immediate.
- I_USE_IMM  input  1  1 = operand B is the immediate (SLTI/SLTIU).
- I_UNSIGNED  input  1  1 = SLTU/SLTIU.
- I_RD  input  RD_W  destination tag.
- I_WB_EN  input  1  writeback valid; used only with SLT_FWD_EN.
- I_WB_RD  input  RD_W  writeback tag; used only with SLT_FWD_EN.
- I_WB_DATA  input  DATA_W  writeback data; used only with SLT_FWD_EN.
- O_VALID  output  1  prepared operands valid toward the comparator and writeback.
- I_READY  input  1  downstream accepts.
- O_OP_A  output  DATA_W  to comparator I_OP_A.
- O_OP_B  output  DATA_W  to comparator I_OP_B.
- O_RD  output  RD_W  destination tag.
- O_UNSIGNED  output  1  op kind, for trace/debug.

Behaviour:
- Clock and reset: single clock I_CLK; reset I_RST_N is asynchronous and active-low.
- Operand preparation (combinational, on the input side):
  - b = I_USE_IMM ? sign_extend(I_IMM) : I_RS2_DATA.
  - a = I_RS1_DATA.
  - If I_UNSIGNED: a[31] and b[31] are inverted. The immediate is still sign-extended for SLTIU, per RV32I.
- Storage: main register M (drives all outputs) and skid register S, each with a valid bit.
- Handshakes:
  - O_READY = ~S.valid, taken straight from the flop.
  - Accept = I_VALID & O_READY. Take = O_VALID & I_READY.
- Per-edge update (flush excluded):
  - M empty, or Take: M loads S if S.valid, else the accepted input, else goes empty.
  - S is cleared after being moved into M. If S is moved and an input is accepted in the same cycle, the input goes into S.
  - M full, no Take, input accepted: the input goes into S.
  - Ordering is strictly FIFO, and no micro-op is ever dropped or duplicated.
- Latency: 1 cycle from Accept to O_VALID when empty. Sustained throughput is 1 per cycle while I_READY=1.
- I_FLUSH (highest priority):
  - Clears M.valid and S.valid at the next edge.
  - A micro-op accepted in the flush cycle is discarded.
  - O_READY=1 on the following cycle.
- Reset: O_VALID=0, O_OP_A=0, O_OP_B=0, O_RD=0, O_UNSIGNED=0, S cleared, so O_READY=1 while in reset and after release.
- Reset asserted mid-transfer empties both entries immediately. No partial state survives.
- Data held in M stays stable while O_VALID=1 & I_READY=0.
- Rd=x0 is passed through unchanged; suppressing it is the writeback stage's job.

Optional Feature:
- Macro: SLT_FWD_EN.
- Defined:
  - Before selection, rs1 is replaced by I_WB_DATA when I_WB_EN & (I_WB_RD==I_RS1_ADDR) & (I_RS1_ADDR!=0).
  - rs2 is replaced under the same rule when I_USE_IMM=0.
  - Forwarding is evaluated only on the Accept cycle. Entries already in M or S are not updated.
- Undefined: I_WB_* and I_RS*_ADDR are ignored; there is no forwarding logic.

Test Plan:
- After reset, SLTU rs1=0x00000001, rs2=0xFFFFFFFF, I_READY=1 -> next cycle O_VALID=1, O_OP_A=0x80000001, O_OP_B=0x7FFFFFFF. Comparator result is 1.
- SLTI rs1=0xFFFFFFF0, imm=0x005 -> O_OP_A=0xFFFFFFF0, O_OP_B=0x00000005. SLTIU with imm=0xFFF -> O_OP_B=0x7FFFFFFF.
- Back-to-back ops rd=1,2,3 with I_READY=0 for 3 cycles -> O_READY falls after the 2nd accept, rd=1 is held stable. After I_READY=1, rd=1,2,3 emerge in order with no loss.
- I_FLUSH with both entries full while I_VALID=1 -> next cycle O_VALID=0 and O_READY=1, and the flushed rd never appears.
- Assert I_RST_N=0 asynchronously mid-stall -> outputs go to 0 before the next clock edge.
- With SLT_FWD_EN: I_WB_EN=1, I_WB_RD=5, I_WB_DATA=0x12345678, I_RS1_ADDR=5, I_RS1_DATA=0 -> O_OP_A=0x12345678. With I_RS1_ADDR=0 -> O_OP_A=0.

Source files
------------

// File: rtl/slt_operand_stage_if.sv
// Handshake and operand bus between the decode side and the SLT operand stage.
// slave = the stage itself, master = the upstream/downstream environment driving it.
interface slt_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 12,
  parameter int RD_W   = 5
);
  logic              I_VALID;
  logic              O_READY;
  logic [DATA_W-1:0] I_RS1_DATA;
  logic [DATA_W-1:0] I_RS2_DATA;
  logic [RD_W-1:0]   I_RS1_ADDR;
  logic [RD_W-1:0]   I_RS2_ADDR;
  logic [IMM_W-1:0]  I_IMM;
  logic              I_USE_IMM;
  logic              I_UNSIGNED;
  logic [RD_W-1:0]   I_RD;
  logic              I_WB_EN;
  logic [RD_W-1:0]   I_WB_RD;
  logic [DATA_W-1:0] I_WB_DATA;
  logic              O_VALID;
  logic              I_READY;
  logic [DATA_W-1:0] O_OP_A;
  logic [DATA_W-1:0] O_OP_B;
  logic [RD_W-1:0]   O_RD;
  logic              O_UNSIGNED;

  modport slave (
    input  I_VALID, I_RS1_DATA, I_RS2_DATA, I_RS1_ADDR, I_RS2_ADDR, I_IMM,
           I_USE_IMM, I_UNSIGNED, I_RD, I_WB_EN, I_WB_RD, I_WB_DATA, I_READY,
    output O_READY, O_VALID, O_OP_A, O_OP_B, O_RD, O_UNSIGNED
  );

  modport master (
    output I_VALID, I_RS1_DATA, I_RS2_DATA, I_RS1_ADDR, I_RS2_ADDR, I_IMM,
           I_USE_IMM, I_UNSIGNED, I_RD, I_WB_EN, I_WB_RD, I_WB_DATA, I_READY,
    input  O_READY, O_VALID, O_OP_A, O_OP_B, O_RD, O_UNSIGNED
  );
endinterface

// File: rtl/slt_operand_stage.sv
// Prepares SLT/SLTU/SLTI/SLTIU operands for the 32-bit signed comparator; 1 cycle latency.
// 2-entry skid buffer, O_READY comes from a flop; writeback forwarding when SLT_FWD_EN is defined.
module slt_operand_stage #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 12,
  parameter int RD_W   = 5
) (
  input logic                I_CLK,
  input logic                I_RST_N,
  input logic                I_FLUSH,
  slt_operand_stage_if.slave bus
);

  typedef struct packed {
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [RD_W-1:0]   rd;
    logic              uns;
  } op_t;

  logic [DATA_W-1:0] w_rs1;
  logic [DATA_W-1:0] w_rs2;
  logic [DATA_W-1:0] w_imm_ext;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_flip;
  op_t               w_in;
  logic              w_accept;
  logic              w_take;

  op_t  r_m;
  op_t  r_s;
  logic r_m_vld;
  logic r_s_vld;

`ifdef SLT_FWD_EN
  logic w_fwd1;
  logic w_fwd2;
  assign w_fwd1 = bus.I_WB_EN && (bus.I_WB_RD == bus.I_RS1_ADDR) && (bus.I_RS1_ADDR != '0);
  assign w_fwd2 = bus.I_WB_EN && (bus.I_WB_RD == bus.I_RS2_ADDR) && (bus.I_RS2_ADDR != '0)
                  && !bus.I_USE_IMM;
  assign w_rs1  = w_fwd1 ? bus.I_WB_DATA : bus.I_RS1_DATA;
  assign w_rs2  = w_fwd2 ? bus.I_WB_DATA : bus.I_RS2_DATA;
`else
  logic w_unused;
  assign w_unused = &{1'b0, bus.I_RS1_ADDR, bus.I_RS2_ADDR, bus.I_WB_EN, bus.I_WB_RD,
                      bus.I_WB_DATA};
  assign w_rs1    = bus.I_RS1_DATA;
  assign w_rs2    = bus.I_RS2_DATA;
`endif

  // SLTIU still sign-extends; flipping the MSB turns the signed compare into unsigned
  assign w_imm_ext = {{(DATA_W-IMM_W){bus.I_IMM[IMM_W-1]}}, bus.I_IMM};
  assign w_b       = bus.I_USE_IMM ? w_imm_ext : w_rs2;
  assign w_flip    = {bus.I_UNSIGNED, {(DATA_W-1){1'b0}}};

  assign w_in.op_a = w_rs1 ^ w_flip;
  assign w_in.op_b = w_b ^ w_flip;
  assign w_in.rd   = bus.I_RD;
  assign w_in.uns  = bus.I_UNSIGNED;

  assign w_accept = bus.I_VALID && !r_s_vld;
  assign w_take   = r_m_vld && bus.I_READY;

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      r_m     <= '0;
      r_s     <= '0;
      r_m_vld <= 1'b0;
      r_s_vld <= 1'b0;
    end else if (I_FLUSH) begin
      r_m_vld <= 1'b0;
      r_s_vld <= 1'b0;
    end else if (!r_m_vld || w_take) begin
      if (r_s_vld) begin
        r_m     <= r_s;
        r_m_vld <= 1'b1;
        r_s_vld <= w_accept;
        if (w_accept) r_s <= w_in;
      end else begin
        r_m_vld <= w_accept;
        if (w_accept) r_m <= w_in;
      end
    end else if (w_accept) begin
      r_s     <= w_in;
      r_s_vld <= 1'b1;
    end
  end

  assign bus.O_READY    = !r_s_vld;
  assign bus.O_VALID    = r_m_vld;
  assign bus.O_OP_A     = r_m.op_a;
  assign bus.O_OP_B     = r_m.op_b;
  assign bus.O_RD       = r_m.rd;
  assign bus.O_UNSIGNED = r_m.uns;

endmodule
